// File: rtl/riscv_system.sv
// Host-facing system block: word RAM, 8N1 UART and a byte-command monitor
// that loads/inspects RAM and drives the core-halt line.
module riscv_system #(
  parameter  int CLKS_PER_BIT = 434,
  parameter  int RAM_WORDS    = 1024,
  localparam int AW           = $clog2(RAM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rxd,
  output logic          o_txd,
  output logic          o_halt,
  input  logic          i_dbg_override_ctrl,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic          i_dbg_wen,
  input  logic [31:0]   i_dbg_wdata,
  output logic [31:0]   o_dbg_rdata
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] CMD_W = 8'h57, CMD_R = 8'h52, CMD_H = 8'h48, CMD_G = 8'h47;
  localparam logic [7:0] CHR_K = 8'h4B, CHR_Q = 8'h3F;

  typedef enum logic [1:0] {S_IDLE, S_ARGS, S_EXEC, S_REPLY} state_t;

  // ---------------- UART receiver ----------------
  logic [1:0]    r_rx_sync;
  logic          r_rx_d, r_rx_busy, r_rx_valid;
  logic [CW-1:0] r_rx_cnt;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          w_rx;
  assign w_rx = r_rx_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_sync  <= 2'b11;
      r_rx_d     <= 1'b1;
      r_rx_busy  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], i_rxd};
      r_rx_d     <= w_rx;
      r_rx_valid <= 1'b0;
      if (!r_rx_busy) begin
        if (r_rx_d && !w_rx) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt  <= HALF_M1;
          r_rx_bit  <= '0;
        end
      end else if (r_rx_cnt != '0) begin
        r_rx_cnt <= r_rx_cnt - 1'b1;
      end else begin
        r_rx_cnt <= BIT_M1;
        r_rx_bit <= r_rx_bit + 1'b1;
        if (r_rx_bit == 4'd0) begin
          if (w_rx) r_rx_busy <= 1'b0;  // glitch, not a real start bit
        end else if (r_rx_bit == 4'd9) begin
          r_rx_busy  <= 1'b0;
          r_rx_valid <= w_rx;           // low stop bit drops the byte
        end else begin
          r_rx_shift <= {w_rx, r_rx_shift[7:1]};
        end
      end
    end
  end

  // ---------------- UART transmitter ----------------
  logic          r_txd, r_tx_busy;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;
  logic [8:0]    r_tx_shift;
  logic          w_tx_ready, w_tx_start;
  logic [7:0]    w_tx_byte;

  // Ready also in the last stop-bit cycle so consecutive frames abut exactly.
  assign w_tx_ready = !r_tx_busy || (r_tx_cnt == '0 && r_tx_bit == 4'd9);
  assign o_txd      = r_txd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_txd      <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else if (w_tx_start) begin
      r_txd      <= 1'b0;
      r_tx_busy  <= 1'b1;
      r_tx_cnt   <= BIT_M1;
      r_tx_bit   <= '0;
      r_tx_shift <= {1'b1, w_tx_byte};
    end else if (r_tx_busy) begin
      if (r_tx_cnt != '0) begin
        r_tx_cnt <= r_tx_cnt - 1'b1;
      end else if (r_tx_bit == 4'd9) begin
        r_tx_busy <= 1'b0;
      end else begin
        r_txd      <= r_tx_shift[0];
        r_tx_shift <= {1'b1, r_tx_shift[8:1]};
        r_tx_bit   <= r_tx_bit + 1'b1;
        r_tx_cnt   <= BIT_M1;
      end
    end
  end

  // ---------------- Command parser ----------------
  state_t      r_state, w_state_next;
  logic [7:0]  r_cmd, r_buf;
  logic        r_buf_valid, r_halt;
  logic [2:0]  r_arg_cnt;
  logic [15:0] r_addr;
  logic [31:0] r_data, r_ram_rdata, r_dbg_rdata;
  logic [23:0] r_reply_shift;
  logic [1:0]  r_tx_left;
  logic        w_consume, w_par_we, w_reply_go, w_unused;
  logic [7:0]  w_byte, w_reply_first;

  assign w_byte   = r_buf_valid ? r_buf : r_rx_shift;
  assign o_halt   = r_halt;
  assign w_unused = ^(r_addr >> AW);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_consume    = 1'b0;
    w_par_we     = 1'b0;
    w_reply_go   = 1'b0;
    case (r_state)
      S_IDLE: if (r_buf_valid || r_rx_valid) begin
        w_consume    = 1'b1;
        w_state_next = (w_byte == CMD_W || w_byte == CMD_R) ? S_ARGS : S_REPLY;
      end
      S_ARGS: if (r_buf_valid || r_rx_valid) begin
        w_consume = 1'b1;
        if (r_arg_cnt == 3'd1) w_state_next = S_EXEC;
      end
      S_EXEC: begin
        w_par_we     = (r_cmd == CMD_W);
        w_state_next = S_REPLY;
      end
      S_REPLY: if (r_tx_left == 2'd0 && w_tx_ready) begin
        w_reply_go   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (i_dbg_override_ctrl) begin
      w_state_next = S_IDLE;
      w_consume    = 1'b0;
      w_par_we     = 1'b0;
      w_reply_go   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd       <= '0;
      r_buf       <= '0;
      r_buf_valid <= 1'b0;
      r_halt      <= 1'b1;
      r_arg_cnt   <= '0;
      r_addr      <= '0;
      r_data      <= '0;
    end else begin
      // One-byte holding slot covers bytes arriving while a command executes.
      if (i_dbg_override_ctrl) begin
        r_buf_valid <= 1'b0;
      end else if (r_rx_valid && (r_buf_valid || !w_consume)) begin
        r_buf       <= r_rx_shift;
        r_buf_valid <= 1'b1;
      end else if (w_consume) begin
        r_buf_valid <= 1'b0;
      end
      if (w_consume) begin
        if (r_state == S_IDLE) begin
          r_cmd     <= w_byte;
          r_arg_cnt <= (w_byte == CMD_W) ? 3'd6 : 3'd2;
          if (w_byte == CMD_H)      r_halt <= 1'b1;
          else if (w_byte == CMD_G) r_halt <= 1'b0;
        end else begin
          r_arg_cnt <= r_arg_cnt - 1'b1;
          if (r_cmd == CMD_W && r_arg_cnt <= 3'd4) r_data <= {r_data[23:0], w_byte};
          else                                     r_addr <= {r_addr[7:0], w_byte};
        end
      end
    end
  end

  // Reply sender: first byte leaves from REPLY, the rest stream back-to-back.
  assign w_reply_first = (r_cmd == CMD_R) ? r_ram_rdata[31:24] :
                         (r_cmd == CMD_W || r_cmd == CMD_H || r_cmd == CMD_G) ? CHR_K : CHR_Q;
  assign w_tx_start    = w_tx_ready && (r_tx_left != 2'd0 || w_reply_go);
  assign w_tx_byte     = (r_tx_left != 2'd0) ? r_reply_shift[23:16] : w_reply_first;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_left     <= '0;
      r_reply_shift <= '0;
    end else if (w_reply_go) begin
      r_reply_shift <= r_ram_rdata[23:0];
      r_tx_left     <= (r_cmd == CMD_R) ? 2'd3 : 2'd0;
    end else if (w_tx_start) begin
      r_reply_shift <= {r_reply_shift[15:0], 8'h00};
      r_tx_left     <= r_tx_left - 1'b1;
    end
  end

  // ---------------- RAM: arbitrated RW port plus debug read port ----------------
  logic [31:0]   r_ram [RAM_WORDS];
  logic [AW-1:0] w_ram_addr;
  logic          w_ram_we;
  logic [31:0]   w_ram_wdata;

  assign w_ram_addr  = i_dbg_override_ctrl ? i_dbg_addr  : r_addr[AW-1:0];
  assign w_ram_we    = i_dbg_override_ctrl ? i_dbg_wen   : w_par_we;
  assign w_ram_wdata = i_dbg_override_ctrl ? i_dbg_wdata : r_data;

  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_ram_addr] <= w_ram_wdata;
    r_ram_rdata <= r_ram[w_ram_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) r_dbg_rdata <= '0;
    else     r_dbg_rdata <= r_ram[i_dbg_addr];
  end
  assign o_dbg_rdata = r_dbg_rdata;
endmodule

// File: tb/tb_riscv_system.sv
// Drives the host UART, decodes replies from txd and compares against a
// command-level model of RAM, halt state and expected reply bytes.
module tb_riscv_system;
  localparam int CPB       = 8;
  localparam int RAM_WORDS = 64;
  localparam int AW        = 6;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rxd = 1'b1;
  logic          ovr = 1'b0;
  logic          dwen = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic [31:0]   dwdata = '0;
  logic          txd, halt;
  logic [31:0]   drdata;

  riscv_system #(.CLKS_PER_BIT(CPB), .RAM_WORDS(RAM_WORDS)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_rxd               (rxd),
    .o_txd               (txd),
    .o_halt              (halt),
    .i_dbg_override_ctrl (ovr),
    .i_dbg_addr          (daddr),
    .i_dbg_wen           (dwen),
    .i_dbg_wdata         (dwdata),
    .o_dbg_rdata         (drdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  tx_q[$];
  int          tx_t[$];
  logic [31:0] mem[int];
  int          written[$];
  logic        exp_halt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Host-side receiver: sample txd at bit centres, record each byte and its start cycle.
  initial begin
    logic [7:0] b;
    int t;
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        t = cyc;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        tx_q.push_back(b);
        tx_t.push_back(t);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(posedge clk); #1;
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop_ok;
    tick(CPB);
    rxd = 1'b1;
    if (!stop_ok) tick(2 * CPB);
  endtask

  task automatic do_cmd(input string tag, input bq_t cmd, input bq_t exp);
    int waited;
    foreach (cmd[i]) send_byte(cmd[i], 1'b1);
    waited = 0;
    while (tx_q.size() < exp.size() && waited < (exp.size() + 1) * 10 * CPB + 50) begin
      tick(1);
      waited++;
    end
    tick(12 * CPB);
    check({tag, ".count"}, 32'(tx_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < tx_q.size(); i++)
      check($sformatf("%s.byte%0d", tag, i), 32'(tx_q[i]), 32'(exp[i]));
    if (exp.size() == 4 && tx_q.size() == 4)
      check({tag, ".gap"}, 32'(tx_t[3] - tx_t[0]), 32'(30 * CPB));
    $display("txn %-12s sent=%0d reply_bytes=%0d expected=%0d", tag, cmd.size(), tx_q.size(), exp.size());
    tx_q.delete();
    tx_t.delete();
  endtask

  task automatic cmd_write(input string tag, input logic [15:0] a, input logic [31:0] d, input bit expect_reply);
    bq_t c, e;
    c.push_back(8'h57); c.push_back(a[15:8]); c.push_back(a[7:0]);
    c.push_back(d[31:24]); c.push_back(d[23:16]); c.push_back(d[15:8]); c.push_back(d[7:0]);
    if (expect_reply) begin
      e.push_back(8'h4B);
      mem[int'(a) % RAM_WORDS] = d;
    end
    do_cmd(tag, c, e);
  endtask

  task automatic cmd_read(input string tag, input logic [15:0] a);
    bq_t c, e;
    logic [31:0] d;
    d = mem[int'(a) % RAM_WORDS];
    c.push_back(8'h52); c.push_back(a[15:8]); c.push_back(a[7:0]);
    e.push_back(d[31:24]); e.push_back(d[23:16]); e.push_back(d[15:8]); e.push_back(d[7:0]);
    do_cmd(tag, c, e);
  endtask

  task automatic cmd_single(input string tag, input logic [7:0] b);
    bq_t c, e;
    c.push_back(b);
    if (b == 8'h48)      begin exp_halt = 1'b1; e.push_back(8'h4B); end
    else if (b == 8'h47) begin exp_halt = 1'b0; e.push_back(8'h4B); end
    else                 e.push_back(8'h3F);
    do_cmd(tag, c, e);
    @(negedge clk);
    check({tag, ".halt"}, 32'(halt), 32'(exp_halt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt, idx, r;
    logic [15:0] a16;
    logic [7:0]  ob;
    bq_t c, e;

    // Reset state
    exp_halt = 1'b1;
    tick(2);
    @(negedge clk);
    check("rst.rdata", drdata, 32'h0);
    check("rst.txd", 32'(txd), 32'h1);
    check("rst.halt", 32'(halt), 32'h1);
    tick(1);
    rst = 1'b0;
    low_cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd !== 1'b1) low_cnt++;
    end
    check("rst.idle_txd", 32'(low_cnt), 32'h0);
    check("rst.no_tx", 32'(tx_q.size()), 32'h0);

    // UART write then read back, plus debug read without override
    cmd_write("wr5", 16'h0005, 32'hDEADBEEF, 1'b1);
    cmd_read("rd5", 16'h0005);
    daddr = 6'd5;
    tick(2);
    @(negedge clk);
    check("dbg.rd5", drdata, 32'hDEADBEEF);

    // Halt control and unknown command
    cmd_single("go", 8'h47);
    cmd_single("halt", 8'h48);
    cmd_single("unknown", 8'h00);

    // Debug override: direct write, and UART W ignored meanwhile
    cmd_write("wr7", 16'h0007, 32'hCAFEF00D, 1'b1);
    @(posedge clk); #1;
    ovr = 1'b1; daddr = 6'd3; dwdata = 32'h12345678; dwen = 1'b1;
    tick(1);
    dwen = 1'b0;
    mem[3] = 32'h12345678;
    tick(1);
    @(negedge clk);
    check("dbg.wr3", drdata, 32'h12345678);
    cmd_write("ovr_w7", 16'h0007, 32'h11223344, 1'b0);
    @(posedge clk); #1;
    ovr = 1'b0;
    tick(2);
    cmd_read("rd3", 16'h0003);
    cmd_read("rd7", 16'h0007);

    // Framing error: bad-stop H must be ignored
    cmd_single("go2", 8'h47);
    send_byte(8'h48, 1'b0);
    @(negedge clk);
    check("frame.halt_kept", 32'(halt), 32'h0);
    cmd_single("frame_h", 8'h48);

    // Reset in the middle of a W command
    cmd_write("wr9", 16'h0009, 32'hA5A55A5A, 1'b1);
    cmd_single("go3", 8'h47);
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    @(posedge clk); #1;
    rxd = 1'b0;
    tick(CPB);
    rxd = 1'b1;
    tick(2 * CPB);
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    check("midrst.txd", 32'(txd), 32'h1);
    check("midrst.rdata", drdata, 32'h0);
    tick(1);
    rst = 1'b0;
    exp_halt = 1'b1;
    @(negedge clk);
    check("midrst.halt", 32'(halt), 32'h1);
    tick(20 * CPB);
    check("midrst.no_tx", 32'(tx_q.size()), 32'h0);
    cmd_read("rd9", 16'h0009);

    // Randomized command mix against the model
    foreach (mem[k]) written.push_back(k);
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        a16 = 16'($urandom);
        idx = int'(a16) % RAM_WORDS;
        if (!mem.exists(idx)) written.push_back(idx);
        cmd_write($sformatf("rnd%0d.w", k), a16, $urandom, 1'b1);
      end else if (r < 7) begin
        idx = written[$urandom_range(0, written.size() - 1)];
        a16 = 16'(idx + RAM_WORDS * $urandom_range(0, 1023));
        cmd_read($sformatf("rnd%0d.r", k), a16);
        daddr = AW'(idx);
        tick(2);
        @(negedge clk);
        check($sformatf("rnd%0d.dbg", k), drdata, mem[idx]);
      end else if (r < 8) begin
        cmd_single($sformatf("rnd%0d.hg", k), ($urandom_range(0, 1) != 0) ? 8'h48 : 8'h47);
      end else begin
        do ob = 8'($urandom_range(0, 255));
        while (ob == 8'h57 || ob == 8'h52 || ob == 8'h48 || ob == 8'h47);
        cmd_single($sformatf("rnd%0d.x", k), ob);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/riscv_system.md
# riscv_system

Top-level on-chip system block below the board wrapper: word-addressed RAM, 8N1 UART, and a byte-command monitor that loads and inspects RAM and controls the core-halt line. A host drives it over `rxd`/`txd`. A debug bundle (`ram_dump_if`, instance `cpu_ram_debug_if`) can take direct ownership of the RAM. The board wrapper ties `override_ctrl` to 0 and drives the LEDs from `halt`, `txd` and `rxd`.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz at 115200 baud).
- `RAM_WORDS`, default 1024: RAM depth in 32-bit words; power of two; address width `AW = log2(RAM_WORDS)`.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `rxd` input 1: UART receive line; asynchronous to `clk`; idle high.
- `txd` output 1: UART transmit line; idle high.
- `halt` output 1: core hold request; 1 = core halted.
- `cpu_ram_debug_if.override_ctrl` input 1: 1 = the debug port owns the RAM.
- `cpu_ram_debug_if.addr` input AW: debug word address.
- `cpu_ram_debug_if.wen` input 1: debug write enable; honoured only while `override_ctrl` = 1.
- `cpu_ram_debug_if.wdata` input 32: debug write data.
- `cpu_ram_debug_if.rdata` output 32: debug read data, registered.

## Operation
- UART RX
  - 2-FF synchronizer on `rxd`.
  - A falling edge starts a frame. The start bit is re-checked at half a bit time; if it is high, the frame is aborted.
  - Data bits are sampled at bit centres, LSB first, then the stop bit.
  - Stop bit = 0: byte discarded (framing error).
- UART TX
  - 8N1, LSB first.
  - Accepts a byte only when idle.
  - A 4-byte reply is sent back-to-back with no idle gap.
- Command parser (states IDLE, ARGS, EXEC, REPLY). Multi-byte fields are big-endian; only the low AW address bits are used.
  - `W` (0x57) + addr[15:0] (2 bytes) + data[31:0] (4 bytes): write `RAM[addr]`, reply `K` (0x4B).
  - `R` (0x52) + addr (2 bytes): reply the 4 data bytes, MSB first.
  - `H` (0x48): set `halt` = 1, reply `K`.
  - `G` (0x47): set `halt` = 0, reply `K`.
  - Any other byte in IDLE: reply `?` (0x3F), stay in IDLE.
  - No inter-byte timeout. Bytes that arrive during REPLY are still parsed as the next command; single-byte buffering is sufficient.
- RAM arbitration
  - `override_ctrl` = 1: the debug port drives address, write enable and write data. The parser is forced to IDLE and received bytes are dropped. A reply already in progress finishes transmitting.
  - `override_ctrl` = 0: the parser owns the RAM. `cpu_ram_debug_if.rdata` keeps tracking `RAM[addr]`, so a debug read is possible without override.
- Reset values: `txd` = 1, `halt` = 1, `cpu_ram_debug_if.rdata` = 0, parser IDLE, RX/TX idle.
- RAM contents are not cleared by reset.
- Asserting `rst` mid-frame aborts RX and TX immediately. `txd` returns high on the next edge.

## Timing
- RAM read latency is 1 cycle; write takes effect on the edge where write enable is sampled.
- Debug read: `rdata` is valid on the edge after `addr` is presented. Write-then-read of the same address returns the new data on the cycle after the write.
- RX byte valid: a 1-cycle strobe, issued on the cycle after the stop-bit sample (the sample falls at 9.5 bit times after the start edge, plus 2 synchronizer cycles).
- Reply start: the TX start bit begins no more than 3 cycles after the last command byte's RX strobe.
- `halt` changes on the cycle after the `H`/`G` strobe, before the `K` reply starts.
- Bit period is exactly `CLKS_PER_BIT` cycles; a frame is `10 × CLKS_PER_BIT` cycles.
- Override handover takes 1 cycle. A write from the parser in the same cycle that `override_ctrl` rises is dropped; the debug port has priority.

## Test plan
All scenarios use `CLKS_PER_BIT` = 8.
- Reset: hold `rst` 2 cycles → `txd` = 1, `halt` = 1, `rdata` = 0; no TX activity for 200 cycles.
- UART write/read: send 57 00 05 DE AD BE EF → `K` received; then send 52 00 05 → bytes DE AD BE EF in that order; `rdata` reads 0xDEADBEEF with debug `addr` = 5.
- Halt control: send 47 → `halt` = 0, reply 4B; send 48 → `halt` = 1, reply 4B; send 0x00 → reply 3F and `halt` unchanged.
- Debug override: `override_ctrl` = 1, write 0x12345678 to addr 3; then `override_ctrl` = 0 and send 52 00 03 → reply 12 34 56 78. A `W` sent during override produces no reply and no write.
- Framing error: send a frame with stop bit = 0, then 48 → only one reply (4B); the bad byte is ignored.
- Reset mid-operation: assert `rst` during the third byte of a `W` command → `txd` high, `halt` = 1; the following `R` of the same address shows no write occurred.
